gray2bin_pipe: RTL and testbench
================================

# gray2bin_pipe

Pipelined Gray-to-binary decoder with valid/ready handshake on both sides. It is the receiving end of Gray-coded counter and pointer paths, such as FIFO pointers after synchronisation and Gray-coded sequence counters. Each accepted word is checked against the previous accepted word for a legal single-bit Gray step. A per-beat error flag and a sticky error flag report illegal steps.

## Interface
- WIDTH, 32, Gray/binary word width (≥2)
- ALLOW_HOLD, 1, 1: a repeated identical word (distance 0) is legal; 0: repeat flags an error
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush: empties pipeline, clears sticky error, re-arms first-word state
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_gray  in  WIDTH  Gray-coded input word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_bin  out  WIDTH  decoded binary word
- out_step_err  out  1  this beat was an illegal step from the previous accepted word
- err_sticky  out  1  set by any out_step_err beat leaving stage 1; held until clr or rst

## Operation
- Decode: out_bin[WIDTH-1] = g[WIDTH-1]; out_bin[i] = out_bin[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Two register stages:
  - S1 captures in_gray, the step-check result, and valid.
  - S2 captures the decoded binary word, err, and valid.
- Step check at acceptance:
  - d = in_gray ^ prev_gray.
  - Legal if d has exactly one bit set, i.e. d != 0 && (d & (d-1)) == 0.
  - Also legal if d == 0 and ALLOW_HOLD = 1.
  - prev_gray updates on every accepted word, including erroneous ones.
- First word after rst or clr is never flagged; a first_n flag marks when prev_gray is valid.
- Wrap-around: 100…0 → 000…0 is a one-bit change and is legal, with no special case.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !clr
- Backpressure: the pipeline holds two words when out_ready is low; out_bin and out_step_err stay stable while out_valid && !out_ready.
- clr has priority over all handshakes in its cycle:
  - No input is accepted and no output counts as transferred.
  - s1_valid, s2_valid, err_sticky and first_n are cleared next edge.
- err_sticky sets when an S1 word with err = 1 advances into S2.
- err_sticky is set with the same edge that makes the erroneous beat visible on out_step_err.

## Timing
- Reset values:
  - in_ready = 0 while rst is asserted, 1 on the first cycle after release.
  - out_valid = 0, out_bin = 0, out_step_err = 0, err_sticky = 0.
  - prev_gray = 0, first_n = 0.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+1, when the output is unstalled.
- Throughput: one word per cycle while out_ready = 1.
- Capacity: 2 words.
  - in_ready goes low only when both stages are full and out_ready = 0.
  - in_ready is combinational from out_ready.
- Simultaneous accept and output transfer in the same cycle is required; there are no bubbles at full rate.
- rst asserted mid-stream: all state clears immediately (asynchronously); in-flight words are discarded.

## Test plan
- WIDTH=4, back-to-back in_gray 0000,0001,0011,0010,0110 with out_ready = 1:
  - out_bin = 0,1,2,3,4 on consecutive cycles, first result after 2 edges.
  - out_step_err = 0 throughout, err_sticky = 0.
- Full count 0..15 and wrap, Gray 1000 → 0000:
  - out_bin 15 then 0, no error.
- Illegal jump 0001 → 0111 (two bits):
  - That beat has out_step_err = 1; err_sticky = 1 from then on.
  - The next word 0101 (one bit from 0111) has out_step_err = 0.
- ALLOW_HOLD=0, input 0011 twice:
  - The second beat is flagged.
  - With ALLOW_HOLD=1 the same stimulus gives no flag.
- Backpressure: out_ready = 0 for 4 cycles while in_valid = 1 with words A,B,C:
  - A and B are accepted, then in_ready = 0.
  - out_bin holds decode(A) stable.
  - On out_ready = 1, A, B, C emerge in order with no loss or duplication.
- clr pulse with 2 words in flight and err_sticky = 1:
  - Next cycle out_valid = 0 and err_sticky = 0.
  - The following word is unflagged regardless of its value.
  - Async rst mid-stream gives the same result immediately.

Source files
------------

// File: rtl/gray2bin_pipe_if.sv
// Stream bundle for the Gray-to-binary decoder: input word handshake,
// output word handshake, flush request and the two error indications.
interface gray2bin_pipe_if #(
  parameter int WIDTH = 32
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_step_err;
  logic             err_sticky;

  // Producer/consumer side (drives words in, accepts decoded words)
  modport master (
    output clr, in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, out_step_err, err_sticky
  );

  // Decoder side
  modport slave (
    input  clr, in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, out_step_err, err_sticky
  );
endinterface

// File: rtl/gray2bin_pipe.sv
// Two-stage pipelined Gray-to-binary decoder with valid/ready on both sides.
// Every accepted word is compared with the previously accepted word; a step
// that is not a single-bit change (or a repeat, when holds are disallowed)
// is flagged on that beat and latched into a sticky error flag.
module gray2bin_pipe #(
  parameter int WIDTH      = 32,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  gray2bin_pipe_if.slave bus
);

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Legal step: exactly one bit differs, or no bit differs when holds are allowed.
  function automatic logic step_legal(input logic [WIDTH-1:0] cur,
                                      input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] d;
    logic             onehot;
    d      = cur ^ prev;
    onehot = (d != '0) && ((d & (d - WIDTH'(1))) == '0);
    return onehot || ((d == '0) && ALLOW_HOLD);
  endfunction

  logic             vld_p1;
  logic             err_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             vld_p2;
  logic             err_p2;
  logic [WIDTH-1:0] bin_p2;
  logic [WIDTH-1:0] prev_gray;
  logic             first_n;
  logic             sticky;
  logic             adv_p1;
  logic             adv_p2;
  logic             in_ready;
  logic             accept;
  logic             step_err;

  // Flow control and step check; ready is held low during reset and flush.
  always_comb begin
    adv_p2   = !vld_p2 || bus.out_ready;
    adv_p1   = !vld_p1 || adv_p2;
    in_ready = adv_p1 && !bus.clr && !rst;
    accept   = bus.in_valid && in_ready;
    step_err = first_n && !step_legal(bus.in_gray, prev_gray);
  end

  // ---- stage 1: capture raw Gray word and its step-check result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      gray_p1 <= '0;
    end else if (bus.clr) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= accept;
      if (accept) begin
        gray_p1 <= bus.in_gray;
        err_p1  <= step_err;
      end
    end
  end

  // ---- stage 2: decoded binary word presented to the consumer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      err_p2 <= 1'b0;
      bin_p2 <= '0;
    end else if (bus.clr) begin
      vld_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        bin_p2 <= gray_to_bin(gray_p1);
        err_p2 <= err_p1;
      end
    end
  end

  // Previous-word tracking and sticky error; sticky sets as the bad beat enters stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray <= '0;
      first_n   <= 1'b0;
      sticky    <= 1'b0;
    end else if (bus.clr) begin
      first_n <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      if (accept) begin
        prev_gray <= bus.in_gray;
        first_n   <= 1'b1;
      end
      if (adv_p2 && vld_p1 && err_p1) begin
        sticky <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = vld_p2;
  assign bus.out_bin      = bin_p2;
  assign bus.out_step_err = err_p2;
  assign bus.err_sticky   = sticky;

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Bench for gray2bin_pipe: two 4-bit instances (hold allowed / hold illegal)
// share one stimulus stream; expected words go into a queue when accepted
// and a negedge monitor pops and compares whenever an output transfers.
module tb_gray2bin_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         ordy = 1'b1;
  logic [W-1:0] in_gray = '0;

  gray2bin_pipe_if #(.WIDTH(W)) if_h ();
  gray2bin_pipe_if #(.WIDTH(W)) if_n ();

  assign if_h.clr = clr;
  assign if_h.in_valid = in_valid;
  assign if_h.in_gray = in_gray;
  assign if_h.out_ready = ordy;
  assign if_n.clr = clr;
  assign if_n.in_valid = in_valid;
  assign if_n.in_gray = in_gray;
  assign if_n.out_ready = ordy;

  gray2bin_pipe #(.WIDTH(W), .ALLOW_HOLD(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(if_h));
  gray2bin_pipe #(.WIDTH(W), .ALLOW_HOLD(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic         eh;
    logic         en;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a word and hold it until accepted; push its expected result.
  task automatic send(input logic [W-1:0] g, input logic [W-1:0] b,
                      input logic eh, input logic en);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_gray = g;
    while (!acc && t <= 20) begin
      @(negedge clk);
      acc = if_h.in_ready && in_valid;
      @(posedge clk);
      #1;
      t++;
    end
    if (acc) sb.push_back('{b, eh, en});
    else begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: word %b never accepted", g);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    sb.delete();
  endtask

  // Monitor: compare transferred beats, check stall stability and sticky timing.
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_bin;
  logic         stall_err;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", if_h.out_valid, 1);
        chk("hold_bin", if_h.out_bin, stall_bin);
        chk("hold_err", if_h.out_step_err, stall_err);
      end
      if (!clr && if_h.out_valid && ordy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: out_bin %0d with empty queue", if_h.out_bin);
        end else begin
          e = sb.pop_front();
          chk("bin_h", if_h.out_bin, e.bin);
          chk("err_h", if_h.out_step_err, e.eh);
          chk("valid_n", if_n.out_valid, 1);
          chk("bin_n", if_n.out_bin, e.bin);
          chk("err_n", if_n.out_step_err, e.en);
        end
      end
      if (if_h.out_valid && if_h.out_step_err) chk("sticky_with_err_h", if_h.err_sticky, 1);
      if (if_n.out_valid && if_n.out_step_err) chk("sticky_with_err_n", if_n.err_sticky, 1);
      stall_q   = !clr && if_h.out_valid && !ordy;
      stall_bin = if_h.out_bin;
      stall_err = if_h.out_step_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] g;
    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", if_h.in_ready, 0);
    chk("rst_out_valid", if_h.out_valid, 0);
    chk("rst_out_bin", if_h.out_bin, 0);
    chk("rst_step_err", if_h.out_step_err, 0);
    chk("rst_sticky", if_h.err_sticky, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rel_in_ready_h", if_h.in_ready, 1);
    chk("rel_in_ready_n", if_n.in_ready, 1);

    // back-to-back counting with latency check
    send(4'b0000, 4'd0, 0, 0);
    chk("lat_not_yet", if_h.out_valid, 0);
    send(4'b0001, 4'd1, 0, 0);
    chk("lat_valid", if_h.out_valid, 1);
    chk("lat_bin", if_h.out_bin, 0);
    send(4'b0011, 4'd2, 0, 0);
    send(4'b0010, 4'd3, 0, 0);
    send(4'b0110, 4'd4, 0, 0);
    drain();
    chk("t1_sticky", if_h.err_sticky, 0);

    // full count and wrap 1000 -> 0000
    pulse_clr();
    for (int i = 0; i < 16; i++) begin
      g = W'(i) ^ (W'(i) >> 1);
      send(g, W'(i), 0, 0);
    end
    send(4'b0000, 4'd0, 0, 0);
    drain();
    chk("t2_sticky_h", if_h.err_sticky, 0);
    chk("t2_sticky_n", if_n.err_sticky, 0);

    // illegal two-bit jump then a legal step
    pulse_clr();
    send(4'b0001, 4'd1, 0, 0);
    send(4'b0111, 4'd5, 1, 1);
    send(4'b0101, 4'd6, 0, 0);
    drain();
    chk("t3_sticky_h", if_h.err_sticky, 1);

    // repeated word: legal only with holds allowed
    pulse_clr();
    send(4'b0011, 4'd2, 0, 0);
    send(4'b0011, 4'd2, 0, 1);
    drain();
    chk("t4_sticky_h", if_h.err_sticky, 0);
    chk("t4_sticky_n", if_n.err_sticky, 1);

    // backpressure: A,B fill the pipe, C waits
    pulse_clr();
    ordy = 1'b0;
    send(4'b0000, 4'd0, 0, 0);
    send(4'b0001, 4'd1, 0, 0);
    in_valid = 1'b1;
    in_gray = 4'b0011;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready_h", if_h.in_ready, 0);
      chk("bp_in_ready_n", if_n.in_ready, 0);
      chk("bp_valid", if_h.out_valid, 1);
      chk("bp_bin", if_h.out_bin, 0);
    end
    @(posedge clk);
    #1;
    ordy = 1'b1;
    send(4'b0011, 4'd2, 0, 0);
    drain();

    // flush with two words in flight and sticky set
    pulse_clr();
    send(4'b0001, 4'd1, 0, 0);
    send(4'b0111, 4'd5, 1, 1);
    drain();
    ordy = 1'b0;
    send(4'b0101, 4'd6, 0, 0);
    send(4'b0100, 4'd7, 0, 0);
    in_valid = 1'b0;
    chk("t6_sticky_pre", if_h.err_sticky, 1);
    chk("t6_full_valid", if_h.out_valid, 1);
    pulse_clr();
    chk("t6_clr_valid_h", if_h.out_valid, 0);
    chk("t6_clr_valid_n", if_n.out_valid, 0);
    chk("t6_clr_sticky_h", if_h.err_sticky, 0);
    chk("t6_clr_sticky_n", if_n.err_sticky, 0);
    ordy = 1'b1;
    send(4'b1010, 4'd12, 0, 0);
    drain();

    // asynchronous reset mid-stream
    send(4'b0101, 4'd6, 1, 1);
    drain();
    ordy = 1'b0;
    send(4'b0100, 4'd7, 0, 0);
    send(4'b0110, 4'd4, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", if_h.out_valid, 0);
    chk("arst_bin", if_h.out_bin, 0);
    chk("arst_sticky_h", if_h.err_sticky, 0);
    chk("arst_sticky_n", if_n.err_sticky, 0);
    chk("arst_in_ready", if_h.in_ready, 0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    ordy = 1'b1;
    send(4'b1111, 4'd10, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
